// File: rtl/stage_in_fifo.sv
// Purpose: show-ahead elastic input buffer in front of the registered data stage,
//          with occupancy and a clearable high-water mark for bring-up diagnostics.
// Latency: a word accepted at edge N is on out_data_o/out_valid_o right after edge N.
// Backpressure: in_ready_o drops only when full; it is not relaxed by a same-cycle pop.
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-high reset
//   in_valid_i/in_ready_o    producer handshake, in_data_i is the offered word
//   out_valid_o/out_ready_i  consumer handshake, out_data_o is the oldest word (zero when empty)
//   level_o                  stored word count, 0..DEPTH
//   hwm_o/hwm_clr_i          high-water mark and its synchronous clear
module stage_in_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           out_data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [$clog2(DEPTH):0]     hwm_o,
   input  logic                       hwm_clr_i
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [LW-1:0]    hwm_q, hwm_d;
   logic             push, pop;

   // Handshake status comes from the registered level only, so neither ready
   // nor valid has a combinational path from the opposite side.
   assign in_ready_o  = (level_q != FULL_LVL);
   assign out_valid_o = (level_q != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
   assign level_o     = level_q;
   assign hwm_o       = hwm_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Clear takes priority and restarts tracking from the fill being entered.
   always_comb begin
      hwm_d = hwm_q;
      if (hwm_clr_i)
         hwm_d = level_d;
      else if (level_d > hwm_q)
         hwm_d = level_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         hwm_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         hwm_q    <= hwm_d;
      end
   end

   // Storage is deliberately left out of reset; stale entries are unreachable
   // because out_data_o is masked whenever the level is zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

endmodule

// File: tb/tb_stage_in_fifo.sv
module tb_stage_in_fifo;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] level;
   logic [2:0] hwm;
   logic       hwm_clr;

   stage_in_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .level_o     (level),
      .hwm_o       (hwm),
      .hwm_clr_i   (hwm_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];   // scoreboard of accepted words, oldest first
   int         m_cnt = 0;  // reference occupancy
   int         m_hwm = 0;  // reference high-water mark

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".level"},     int'(level),     m_cnt);
      chk({tag, ".hwm"},       int'(hwm),       m_hwm);
      chk({tag, ".in_ready"},  int'(in_ready),  int'(m_cnt < DEPTH));
      chk({tag, ".out_valid"}, int'(out_valid), int'(m_cnt > 0));
      if (m_cnt == 0) chk({tag, ".out_data_zero"}, int'(out_data), 0);
   endtask

   // One clock of stimulus. Called at posedge+1; returns at the next posedge+1
   // after checking the registered status against the reference model.
   task automatic step(input string tag, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic clr);
      bit acc, tk;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      hwm_clr   = clr;
      acc = iv && (m_cnt < DEPTH);
      tk  = ordy && (m_cnt > 0);
      if (acc) exp_q.push_back(d);
      m_cnt = m_cnt + int'(acc) - int'(tk);
      if (clr)              m_hwm = m_cnt;
      else if (m_cnt > m_hwm) m_hwm = m_cnt;
      @(posedge clk);
      #1;
      chk_status(tag);
   endtask

   // Data monitor: mid-cycle, every consumer handshake must deliver the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got %0h, expected no word", out_data);
            end else begin
               chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hwm_clr = 1'b0;
      #2 rst = 1'b1;
      #2;
      chk_status("reset0");
      chk("reset0.out_data", int'(out_data), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Fill to full, offer a 5th word that must be refused, then drain in order.
      step("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
      step("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
      step("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
      step("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
      step("full_hold", 1'b1, 8'h55, 1'b0, 1'b0);
      step("full_hold2", 1'b1, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h55, 1'b1, 1'b0);
      step("late55", 1'b1, 8'h55, 1'b0, 1'b0);
      step("pop55", 1'b0, 8'h00, 1'b1, 1'b0);

      // Streaming: level settles at 1, hwm restarts from the clear.
      for (int i = 0; i < 20; i++)
         step("stream", 1'b1, 8'(i), 1'b1, (i == 0));
      step("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);

      // Empty boundary: pop request while empty changes nothing.
      step("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);
      step("empty_pop2", 1'b0, 8'h00, 1'b1, 1'b0);

      // Full boundary: push and pop together at full -> pop only.
      for (int i = 0; i < 4; i++) step("refill", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      step("full_pp", 1'b1, 8'hEE, 1'b1, 1'b0);

      // hwm clear: drain to 1, clear, then one push raises it to 2.
      step("hd0", 1'b0, 8'h00, 1'b1, 1'b0);
      step("hd1", 1'b0, 8'h00, 1'b1, 1'b0);
      step("hwm_clr", 1'b0, 8'h00, 1'b0, 1'b1);
      step("hwm_push", 1'b1, 8'hB7, 1'b0, 1'b0);
      while (m_cnt > 0) step("hdrain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Wrap-around: push, push, pop pattern, then drain.
      for (int i = 0; i < 12; i++)
         step("wrap", (i % 3 != 2), 8'hC0 + 8'(i), (i % 3 == 2), 1'b0);
      while (m_cnt > 0) step("wdrain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Randomized traffic with occasional hwm clears.
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

      // Async reset mid-traffic at level 3.
      while (m_cnt < 3) step("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
      while (m_cnt > 3) step("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      m_cnt = 0;
      m_hwm = 0;
      chk_status("async_rst");
      chk("async_rst.out_data", int'(out_data), 0);
      @(posedge clk); #1;
      chk_status("rst_held");
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
      step("post_rst_push", 1'b1, 8'h5A, 1'b0, 1'b0);
      step("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

      step("final_idle", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
